lcd_cmd_arbiter: RTL and testbench

LCD_CMD_ARBITER -- requirements
Module: lcd_cmd_arbiter

---
 rtl/lcd_cmd_arbiter.sv | 145 ++++++++++++++
 tb/tb_lcd_cmd_arbiter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_cmd_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : lcd_cmd_arbiter                                                   |
// | Brief   : Two-requester byte arbiter feeding a nibble-level LCD FSM, with   |
// |           bounded cfg bursts, done timeout and per-command settle delays.   |
// | Revision: 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+
module lcd_cmd_arbiter #(
    parameter int SHORT_WAIT   = 2000,
    parameter int LONG_WAIT    = 82000,
    parameter int MAX_CFG_RUN  = 4,
    parameter int DONE_TIMEOUT = 8191
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cfg_valid,
    output logic       cfg_ready,
    input  logic [7:0] cfg_data,
    input  logic       txt_valid,
    output logic       txt_ready,
    input  logic [7:0] txt_data,
    input  logic       txt_rs,
    output logic [7:0] lcd_byte,
    output logic       lcd_rs,
    output logic       lcd_start,
    input  logic       lcd_done,
    output logic       busy,
    output logic       owner,
    output logic       err_timeout
);
    localparam int c_MAX_WAIT = (SHORT_WAIT > LONG_WAIT) ? SHORT_WAIT : LONG_WAIT;
    localparam int c_MAX_CNT  = (c_MAX_WAIT > DONE_TIMEOUT) ? c_MAX_WAIT : DONE_TIMEOUT;
    localparam int c_CW       = $clog2(c_MAX_CNT + 1);
    localparam int c_RW       = (MAX_CFG_RUN < 1) ? 1 : $clog2(MAX_CFG_RUN + 1);

    localparam logic [1:0] c_IDLE      = 2'd0;
    localparam logic [1:0] c_ISSUE     = 2'd1;
    localparam logic [1:0] c_WAIT_DONE = 2'd2;
    localparam logic [1:0] c_SETTLE    = 2'd3;

    logic [1:0]      state_q, state_d;
    logic [7:0]      byte_q, byte_d;
    logic            rs_q, rs_d;
    logic            owner_q, owner_d;
    logic            err_q, err_d;
    logic [c_RW-1:0] run_q, run_d;
    logic [c_CW-1:0] cnt_q, cnt_d;
    logic            w_long;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= c_IDLE;
            byte_q  <= 8'h00;
            rs_q    <= 1'b0;
            owner_q <= 1'b0;
            err_q   <= 1'b0;
            run_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            byte_q  <= byte_d;
            rs_q    <= rs_d;
            owner_q <= owner_d;
            err_q   <= err_d;
            run_q   <= run_d;
            cnt_q   <= cnt_d;
        end
    end

    // Clear and return-home are the only instructions needing the long settle.
    assign w_long = !rs_q && (byte_q[7:2] == 6'd0);

    always_comb begin
        state_d = state_q;
        byte_d  = byte_q;
        rs_d    = rs_q;
        owner_d = owner_q;
        err_d   = err_q;
        run_d   = run_q;
        cnt_d   = cnt_q;
        case (state_q)
            c_IDLE: begin
                if (cfg_ready) begin
                    byte_d  = cfg_data;
                    rs_d    = 1'b0;
                    owner_d = 1'b0;
                    state_d = c_ISSUE;
                    if (!txt_valid)
                        run_d = '0;
                    else if (run_q != c_RW'(MAX_CFG_RUN))
                        run_d = run_q + 1'b1;
                end else if (txt_ready) begin
                    byte_d  = txt_data;
                    rs_d    = txt_rs;
                    owner_d = 1'b1;
                    run_d   = '0;
                    state_d = c_ISSUE;
                end
            end
            c_ISSUE: begin
                cnt_d   = '0;
                state_d = c_WAIT_DONE;
            end
            c_WAIT_DONE: begin
                if (lcd_done) begin
                    cnt_d   = w_long ? c_CW'(LONG_WAIT) : c_CW'(SHORT_WAIT);
                    state_d = c_SETTLE;
                end else if (cnt_q == c_CW'(DONE_TIMEOUT)) begin
                    err_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = c_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            c_SETTLE: begin
                // Counts down from the loaded value so SETTLE spans exactly that many cycles.
                if (cnt_q <= c_CW'(1)) begin
                    cnt_d   = '0;
                    state_d = c_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = c_IDLE;
        endcase
    end

    always_comb begin
        cfg_ready = 1'b0;
        txt_ready = 1'b0;
        if (reset && (state_q == c_IDLE)) begin
            cfg_ready = cfg_valid && (!txt_valid || (run_q < c_RW'(MAX_CFG_RUN)));
            txt_ready = txt_valid && !cfg_ready;
        end
        lcd_start   = (state_q == c_ISSUE);
        busy        = (state_q != c_IDLE);
        lcd_byte    = byte_q;
        lcd_rs      = rs_q;
        owner       = owner_q;
        err_timeout = err_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_lcd_cmd_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_lcd_cmd_arbiter                                                |
// | Brief   : Directed, table-driven self-checking bench for lcd_cmd_arbiter.   |
// | Revision: 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+
module tb_lcd_cmd_arbiter;
    localparam int SHORT_W = 20;
    localparam int LONG_W  = 60;
    localparam int MAX_RUN = 4;
    localparam int TMO     = 30;

    logic       clk = 1'b0;
    logic       reset;
    logic       cfg_valid, cfg_ready;
    logic [7:0] cfg_data;
    logic       txt_valid, txt_ready;
    logic [7:0] txt_data;
    logic       txt_rs;
    logic [7:0] lcd_byte;
    logic       lcd_rs, lcd_start, lcd_done, busy, owner, err_timeout;

    int n_chk  = 0;
    int n_fail = 0;

    lcd_cmd_arbiter #(
        .SHORT_WAIT  (SHORT_W),
        .LONG_WAIT   (LONG_W),
        .MAX_CFG_RUN (MAX_RUN),
        .DONE_TIMEOUT(TMO)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_data   (cfg_data),
        .txt_valid  (txt_valid),
        .txt_ready  (txt_ready),
        .txt_data   (txt_data),
        .txt_rs     (txt_rs),
        .lcd_byte   (lcd_byte),
        .lcd_rs     (lcd_rs),
        .lcd_start  (lcd_start),
        .lcd_done   (lcd_done),
        .busy       (busy),
        .owner      (owner),
        .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       cv;
        logic [7:0] cd;
        logic       tv;
        logic [7:0] td;
        logic       trs;
        logic       e_cr;
        logic       e_tr;
        logic [7:0] e_byte;
        logic       e_rs;
        logic       e_own;
        int         e_settle;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_byte"}, lcd_byte, 8'h00);
        chk({tag, "_rs"}, lcd_rs, 0);
        chk({tag, "_start"}, lcd_start, 0);
        chk({tag, "_owner"}, owner, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_err"}, err_timeout, 0);
        chk({tag, "_cfg_ready"}, cfg_ready, 0);
        chk({tag, "_txt_ready"}, txt_ready, 0);
    endtask

    // One full transaction from IDLE: handshake, ISSUE, done 5 cycles after start, SETTLE.
    task automatic run_vec(input vec_t v, input bit spur);
        int  n;
        bit  seen;
        chk("idle_busy", busy, 0);
        cfg_valid = v.cv; cfg_data = v.cd;
        txt_valid = v.tv; txt_data = v.td; txt_rs = v.trs;
        #1;
        chk("cfg_ready", cfg_ready, v.e_cr);
        chk("txt_ready", txt_ready, v.e_tr);
        tick();
        cfg_valid = 0; txt_valid = 0;
        chk("start", lcd_start, 1);
        chk("byte", lcd_byte, v.e_byte);
        chk("rs", lcd_rs, v.e_rs);
        chk("owner", owner, v.e_own);
        chk("ready_in_issue", cfg_ready | txt_ready, 0);
        tick();
        chk("start_pulse_width", lcd_start, 0);
        repeat (3) tick();
        lcd_done = 1; tick(); lcd_done = 0;
        n = 0; seen = 0;
        while (busy && n < 500) begin
            lcd_done = spur && (n == 3);
            if (lcd_start) seen = 1;
            tick();
            n++;
        end
        lcd_done = 0;
        chk("settle_len", n, v.e_settle);
        chk("no_restart", seen, 0);
        chk("byte_hold", lcd_byte, v.e_byte);
        chk("owner_hold", owner, v.e_own);
    endtask

    initial begin
        int   n, cyc, dcount, ng;
        bit   both, err_early;
        logic got[6];
        logic exp_own[6];

        //            cv  cd     tv  td     trs  cr tr  byte   rs own settle
        vecs[0] = '{1'b1, 8'h28, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h28, 1'b0, 1'b0, SHORT_W};
        vecs[1] = '{1'b1, 8'h01, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h01, 1'b0, 1'b0, LONG_W};
        vecs[2] = '{1'b1, 8'h02, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h02, 1'b0, 1'b0, LONG_W};
        vecs[3] = '{1'b1, 8'h04, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h04, 1'b0, 1'b0, SHORT_W};
        vecs[4] = '{1'b0, 8'h00, 1'b1, 8'h41, 1'b1, 1'b0, 1'b1, 8'h41, 1'b1, 1'b1, SHORT_W};
        vecs[5] = '{1'b0, 8'h00, 1'b1, 8'h01, 1'b1, 1'b0, 1'b1, 8'h01, 1'b1, 1'b1, SHORT_W};
        vecs[6] = '{1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1, LONG_W};
        vecs[7] = '{1'b1, 8'h0C, 1'b1, 8'h55, 1'b1, 1'b1, 1'b0, 8'h0C, 1'b0, 1'b0, SHORT_W};
        vecs[8] = '{1'b1, 8'h80, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h80, 1'b0, 1'b0, SHORT_W};
        exp_own = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

        // Reset with both requesters active: nothing may be granted.
        reset = 0; lcd_done = 0;
        cfg_valid = 1; cfg_data = 8'hFF; txt_valid = 1; txt_data = 8'hFF; txt_rs = 1;
        tick(); tick();
        chk_reset_values("por");
        cfg_valid = 0; txt_valid = 0;
        reset = 1;
        tick();

        for (int i = 0; i < 9; i++) run_vec(vecs[i], 1'b0);

        // Contention: both valid continuously.
        cfg_valid = 1; cfg_data = 8'h30; txt_valid = 1; txt_data = 8'h61; txt_rs = 1;
        ng = 0; cyc = 0; dcount = -1; both = 0;
        while (ng < 6 && cyc < 2000) begin
            if (cfg_ready && txt_ready) both = 1;
            if (lcd_start) begin
                got[ng] = owner;
                ng++;
                dcount = 2;
            end
            lcd_done = (dcount == 0);
            if (dcount >= 0) dcount--;
            tick();
            cyc++;
        end
        cfg_valid = 0; txt_valid = 0;
        chk("contention_grants", ng, 6);
        chk("never_both_ready", both, 0);
        for (int g = 0; g < 6; g++) chk($sformatf("grant_owner_%0d", g), got[g], exp_own[g]);
        lcd_done = 1; tick(); lcd_done = 0;
        n = 0;
        while (busy && n < 500) begin tick(); n++; end
        chk("contention_drain", busy, 0);

        // Spurious done in IDLE.
        lcd_done = 1; tick(); lcd_done = 0;
        chk("spur_idle_busy", busy, 0);
        chk("spur_idle_start", lcd_start, 0);
        tick();
        chk("spur_idle_busy2", busy, 0);

        // Spurious done in SETTLE must not shorten it.
        run_vec(vecs[0], 1'b1);

        // Timeout: done never arrives.
        cfg_valid = 1; cfg_data = 8'h28; tick(); cfg_valid = 0;
        chk("tmo_start", lcd_start, 1);
        tick();
        n = 0; err_early = 0;
        while (busy && n < 200) begin
            if (err_timeout) err_early = 1;
            tick();
            n++;
        end
        chk("tmo_wait_len", n, TMO + 1);
        chk("tmo_err_early", err_early, 0);
        chk("tmo_err_set", err_timeout, 1);
        tick();
        chk("tmo_idle", busy, 0);
        run_vec(vecs[4], 1'b0);
        chk("tmo_err_sticky", err_timeout, 1);

        // Reset during SETTLE.
        cfg_valid = 1; cfg_data = 8'h01; tick(); cfg_valid = 0;
        tick(); lcd_done = 1; tick(); lcd_done = 0;
        repeat (5) tick();
        chk("pre_rst_settle_busy", busy, 1);
        reset = 0; cfg_valid = 1; txt_valid = 1;
        tick();
        chk_reset_values("rst_settle");
        cfg_valid = 0; txt_valid = 0; reset = 1;
        tick();
        run_vec(vecs[0], 1'b0);

        // Reset during WAIT_DONE, with a done pulse while held in reset.
        txt_valid = 1; txt_data = 8'h41; txt_rs = 1; tick(); txt_valid = 0;
        tick(); tick();
        chk("pre_rst_wait_owner", owner, 1);
        reset = 0;
        tick();
        chk_reset_values("rst_wait");
        lcd_done = 1; tick(); lcd_done = 0;
        chk("rst_hold_start", lcd_start, 0);
        chk("rst_hold_busy", busy, 0);
        reset = 1;
        tick();
        chk("post_rst_start", lcd_start, 0);
        run_vec(vecs[0], 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
